// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds a serial transmitter one byte at a time
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_SIZE = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           wr_data,
    input  logic                 wr_en,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic [7:0]           tx_data,
    output logic                 new_data,
    input  logic                 tx_busy
);
    typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} state_t;
    state_t               state;
    logic [7:0]           mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
    logic                 wr_ok, pop;
    assign full  = count == (ADDR_SIZE+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_ok = wr_en && !full && !rst;
    assign pop   = state == IDLE && !empty && !tx_busy;
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;
    // GUARD skips one tx_busy sample because the transmitter's busy lags new_data
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            new_data <= 1'b0;
            tx_data  <= 8'h00;
            state    <= IDLE;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_SIZE'(1);
            if (pop) tx_data <= mem[rd_ptr];
            if (wr_en && full) overflow <= 1'b1;
            count    <= count + (ADDR_SIZE+1)'(wr_ok) - (ADDR_SIZE+1)'(pop);
            new_data <= pop;
            state    <= state == IDLE  ? (pop ? SEND : IDLE) :
                        state == SEND  ? GUARD :
                        state == GUARD ? WAIT :
                        (tx_busy ? WAIT : IDLE);
        end
    end
endmodule
